regfile_wr_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback requesters.
- Requester 0 is the ALU writeback path; requester 1 is the load/long-latency unit.
- Round-robin arbitration with valid/ready handshakes; registered write-port outputs feed the register file's write inputs (address, data, write enable).
- Suppresses x0 writes and counts contention cycles for performance monitoring.

---
 rtl/regfile_wr_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Define REGWR_DBG_PORT_EN to add a highest-priority debug write port that ignores stall_i.
module regfile_wr_arbiter #(
    parameter int CNT_W       = 16,
    parameter bit X0_SUPPRESS = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             stall_i,
    input  logic             req0_valid_i,
    input  logic [4:0]       req0_addr_i,
    input  logic [31:0]      req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [4:0]       req1_addr_i,
    input  logic [31:0]      req1_data_i,
    output logic             req1_ready_o,
`ifdef REGWR_DBG_PORT_EN
    input  logic             dbg_valid_i,
    input  logic [4:0]       dbg_addr_i,
    input  logic [31:0]      dbg_data_i,
    output logic             dbg_ready_o,
`endif
    output logic             wr_en_o,
    output logic [4:0]       wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] conflict_cnt_o
);

    logic             last_grant;
    logic             dbg_gnt;
    logic             gnt0;
    logic             gnt1;
    logic             xfer;
    logic [4:0]       win_addr;
    logic [31:0]      win_data;
    logic [CNT_W-1:0] conflict_cnt;

`ifdef REGWR_DBG_PORT_EN
    assign dbg_gnt     = dbg_valid_i;
    assign dbg_ready_o = dbg_valid_i;
`else
    assign dbg_gnt     = 1'b0;
`endif

    // last_grant=1 means requester 1 won most recently, so requester 0 wins the next tie
    assign gnt0 = ~stall_i & ~dbg_gnt & req0_valid_i & (~req1_valid_i | last_grant);
    assign gnt1 = ~stall_i & ~dbg_gnt & req1_valid_i & (~req0_valid_i | ~last_grant);
    assign xfer = gnt0 | gnt1 | dbg_gnt;

    assign req0_ready_o   = gnt0;
    assign req1_ready_o   = gnt1;
    assign busy_o         = (req0_valid_i & ~gnt0) | (req1_valid_i & ~gnt1);
    assign conflict_cnt_o = conflict_cnt;

    always_comb begin
        win_addr = req1_addr_i;
        win_data = req1_data_i;
        if (gnt0) begin
            win_addr = req0_addr_i;
            win_data = req0_data_i;
        end
`ifdef REGWR_DBG_PORT_EN
        if (dbg_gnt) begin
            win_addr = dbg_addr_i;
            win_data = dbg_data_i;
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            wr_en_o    <= 1'b0;
            wr_addr_o  <= 5'd0;
            wr_data_o  <= 32'd0;
            last_grant <= 1'b1;
        end else begin
            if (xfer) begin
                wr_addr_o <= win_addr;
                wr_data_o <= win_data;
                wr_en_o   <= ~(X0_SUPPRESS && (win_addr == 5'd0));
            end else begin
                wr_en_o <= 1'b0;
            end
            if (gnt0) begin
                last_grant <= 1'b0;
            end else if (gnt1) begin
                last_grant <= 1'b1;
            end
        end
    end

    // Counts raw contention, independent of stall or debug activity
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            conflict_cnt <= '0;
        end else if (req0_valid_i && req1_valid_i && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Table-driven bench for regfile_wr_arbiter with a write-port scoreboard.
// Debug-port sequence is compiled in when REGWR_DBG_PORT_EN is defined.
module tb_regfile_wr_arbiter;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sys_clk;
    logic             sys_reset_n;
    logic             stall_i;
    logic             req0_valid_i;
    logic [4:0]       req0_addr_i;
    logic [31:0]      req0_data_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    logic [4:0]       req1_addr_i;
    logic [31:0]      req1_data_i;
    logic             req1_ready_o;
    logic             wr_en_o;
    logic [4:0]       wr_addr_o;
    logic [31:0]      wr_data_o;
    logic             busy_o;
    logic [CNT_W-1:0] conflict_cnt_o;
`ifdef REGWR_DBG_PORT_EN
    logic             dbg_valid_i;
    logic [4:0]       dbg_addr_i;
    logic [31:0]      dbg_data_i;
    logic             dbg_ready_o;
`endif

    regfile_wr_arbiter #(.CNT_W(CNT_W), .X0_SUPPRESS(1'b1)) dut (
        .sys_clk        (sys_clk),
        .sys_reset_n    (sys_reset_n),
        .stall_i        (stall_i),
        .req0_valid_i   (req0_valid_i),
        .req0_addr_i    (req0_addr_i),
        .req0_data_i    (req0_data_i),
        .req0_ready_o   (req0_ready_o),
        .req1_valid_i   (req1_valid_i),
        .req1_addr_i    (req1_addr_i),
        .req1_data_i    (req1_data_i),
        .req1_ready_o   (req1_ready_o),
`ifdef REGWR_DBG_PORT_EN
        .dbg_valid_i    (dbg_valid_i),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_data_i     (dbg_data_i),
        .dbg_ready_o    (dbg_ready_o),
`endif
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .busy_o         (busy_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    typedef struct packed {
        logic        stall;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        e_r0;
        logic        e_r1;
        logic        e_busy;
    } vec_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t             tbl[$];
    wr_t              sb[$];
    int               tests = 0;
    int               fails = 0;
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [4:0]       exp_addr = '0;
    logic [31:0]      exp_data = '0;
    logic             pend0 = 1'b0;
    logic             pend1 = 1'b0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic st, input logic v0, input logic [4:0] a0,
                                input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                                input logic [31:0] d1, input logic r0, input logic r1,
                                input logic bsy);
        vec_t v;
        v.stall = st; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.e_r0 = r0; v.e_r1 = r1; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; leaves just after the next rising edge
    task automatic run_row(input vec_t v, input string tag);
        wr_t e;
        stall_i      = v.stall;
        req0_valid_i = v.v0; req0_addr_i = v.a0; req0_data_i = v.d0;
        req1_valid_i = v.v1; req1_addr_i = v.a1; req1_data_i = v.d1;
        @(negedge sys_clk);
        chk({tag, "_ready0"}, {31'd0, req0_ready_o}, {31'd0, v.e_r0});
        chk({tag, "_ready1"}, {31'd0, req1_ready_o}, {31'd0, v.e_r1});
        chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, v.e_busy});
        chk({tag, "_conflict_cnt"}, {{(32-CNT_W){1'b0}}, conflict_cnt_o}, {{(32-CNT_W){1'b0}}, exp_cnt});
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_wr_en"}, {31'd0, wr_en_o}, {31'd0, e.en});
            chk({tag, "_wr_addr"}, {27'd0, wr_addr_o}, {27'd0, e.addr});
            chk({tag, "_wr_data"}, wr_data_o, e.data);
        end
        if (v.v0 && v.v1 && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
        if (v.e_r0) begin
            exp_addr = v.a0; exp_data = v.d0;
        end else if (v.e_r1) begin
            exp_addr = v.a1; exp_data = v.d1;
        end
        e.en   = (v.e_r0 | v.e_r1) && (exp_addr != 5'd0);
        e.addr = exp_addr;
        e.data = exp_data;
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        if (sys_reset_n) begin
            if (req0_ready_o && req1_ready_o) begin
                fails++;
                $display("FAIL both_ready: got ready0=1 ready1=1 expected at most one at %0t", $time);
            end
            if ((req0_ready_o && !req0_valid_i) || (req1_ready_o && !req1_valid_i)) begin
                fails++;
                $display("FAIL ready_wo_valid: got r0=%b v0=%b r1=%b v1=%b at %0t",
                         req0_ready_o, req0_valid_i, req1_ready_o, req1_valid_i, $time);
            end
        end
    end

    always @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if ((pend0 && !req0_valid_i) || (pend1 && !req1_valid_i)) begin
                fails++;
                $display("FAIL valid_withdrawn: got v0=%b v1=%b with pending p0=%b p1=%b at %0t",
                         req0_valid_i, req1_valid_i, pend0, pend1, $time);
            end
            pend0 <= req0_valid_i & ~req0_ready_o;
            pend1 <= req1_valid_i & ~req1_ready_o;
        end
    end

    initial begin
        // basic single transfer, x0 suppression
        tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0, 0, 0));
        // round-robin with both valid
        tbl.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 1, 1));
        // stall with contention, then resolve
        tbl.push_back(mk(1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0,      1, 2, 32'h22, 0, 1, 0));
        // stall for 3 cycles with only req0
        tbl.push_back(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 32'h33, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0, 0, 0, 0));

        sys_reset_n  = 1'b0;
        stall_i      = 1'b0;
        req0_valid_i = 1'b0; req0_addr_i = '0; req0_data_i = '0;
        req1_valid_i = 1'b0; req1_addr_i = '0; req1_data_i = '0;
`ifdef REGWR_DBG_PORT_EN
        dbg_valid_i = 1'b0; dbg_addr_i = '0; dbg_data_i = '0;
`endif
        #12;
        sys_reset_n = 1'b1;
        @(negedge sys_clk);
        chk("reset_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("reset_wr_addr", {27'd0, wr_addr_o}, 32'd0);
        chk("reset_wr_data", wr_data_o, 32'd0);
        chk("reset_cnt", {{(32-CNT_W){1'b0}}, conflict_cnt_o}, 32'd0);
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

        // sustained contention drives the counter into saturation
        for (int k = 0; k < 12; k++)
            run_row(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, k[0], ~k[0], 1), $sformatf("sat%0d", k));
        run_row(mk(0, 0, 0, 0, 1, 2, 32'h22, 0, 1, 0), "sat_tail");
        run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_idle");
        run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_idle2");

        // asynchronous reset while a write is on the port
        req0_valid_i = 1'b1; req0_addr_i = 5'd9; req0_data_i = 32'h99;
        @(posedge sys_clk);
        #1;
        chk("rst_pre_wr_en", {31'd0, wr_en_o}, 32'd1);
        req0_valid_i = 1'b0;
        #1;
        sys_reset_n = 1'b0;
        #1;
        chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
        chk("rst_wr_addr", {27'd0, wr_addr_o}, 32'd0);
        chk("rst_cnt", {{(32-CNT_W){1'b0}}, conflict_cnt_o}, 32'd0);
        sb.delete();
        exp_cnt = '0; exp_addr = '0; exp_data = '0;
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        @(posedge sys_clk);
        #1;
        run_row(mk(0, 1, 1, 32'hA1, 1, 2, 32'hB2, 1, 0, 1), "post_rst_both");
        run_row(mk(0, 0, 0, 0,      1, 2, 32'hB2, 0, 1, 0), "post_rst_r1");
        run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle");
        run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_rst_idle2");

`ifdef REGWR_DBG_PORT_EN
        sb.delete();
        stall_i = 1'b1;
        dbg_valid_i = 1'b1; dbg_addr_i = 5'd7; dbg_data_i = 32'h1234;
        req0_valid_i = 1'b1; req0_addr_i = 5'd1; req0_data_i = 32'h11;
        req1_valid_i = 1'b1; req1_addr_i = 5'd2; req1_data_i = 32'h22;
        @(negedge sys_clk);
        chk("dbg_ready", {31'd0, dbg_ready_o}, 32'd1);
        chk("dbg_r0", {31'd0, req0_ready_o}, 32'd0);
        chk("dbg_r1", {31'd0, req1_ready_o}, 32'd0);
        if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
        @(posedge sys_clk);
        #1;
        dbg_valid_i = 1'b0;
        chk("dbg_wr_en", {31'd0, wr_en_o}, 32'd1);
        chk("dbg_wr_addr", {27'd0, wr_addr_o}, 32'd7);
        chk("dbg_wr_data", wr_data_o, 32'h1234);
        exp_addr = 5'd7; exp_data = 32'h1234;
        run_row(mk(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 0, 1), "dbg_after_both");
        run_row(mk(0, 0, 0, 0,      1, 2, 32'h22, 0, 1, 0), "dbg_after_r1");
        run_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "dbg_idle");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
